msf_frame_sequencer: RTL and testbench

MSF_FRAME_SEQUENCER -- requirements
Module: msf_frame_sequencer

---
 rtl/msf_frame_sequencer.sv | 129 ++++++++++++
 tb/tb_msf_frame_sequencer.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/msf_frame_sequencer.sv
// MSF time-code frame sequencer: finds second starts in the demodulated carrier,
// samples the A/B bits, detects the minute marker and tracks the second index.
module msf_frame_sequencer #(
  parameter int T_A       = 15,
  parameter int T_B       = 25,
  parameter int T_MARK    = 45,
  parameter int T_MIN_SEC = 90,
  parameter int T_TIMEOUT = 150
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       data_i,
  output logic       bit_valid_o,
  output logic       bit_a_o,
  output logic       bit_b_o,
  output logic [5:0] sec_o,
  output logic       minute_o,
  output logic       synced_o,
  output logic       err_o
);

  typedef enum logic [1:0] {
    HUNT,
    PULSE,
    GAP
  } state_t;

  localparam logic [7:0] TA_8      = 8'(T_A);
  localparam logic [7:0] TB_8      = 8'(T_B);
  localparam logic [7:0] TMARK_8   = 8'(T_MARK);
  localparam logic [7:0] TMIN_8    = 8'(T_MIN_SEC);
  localparam logic [7:0] TTIME_8   = 8'(T_TIMEOUT);
  localparam logic [7:0] TIMER_MAX = 8'hFF;
  localparam logic [5:0] LAST_SEC  = 6'd59;

  state_t     state;
  logic [7:0] timer;
  logic       sync_1;
  logic       data_s;
  logic       data_d;
  logic       cont;
  logic       a;
  logic       b;
  logic       rise;

  // A second starts where the carrier switches off (data_s 0 -> 1).
  assign rise = data_s & ~data_d;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= HUNT;
      timer       <= '0;
      sync_1      <= 1'b0;
      data_s      <= 1'b0;
      data_d      <= 1'b0;
      cont        <= 1'b0;
      a           <= 1'b0;
      b           <= 1'b0;
      bit_valid_o <= 1'b0;
      bit_a_o     <= 1'b0;
      bit_b_o     <= 1'b0;
      sec_o       <= '0;
      minute_o    <= 1'b0;
      synced_o    <= 1'b0;
      err_o       <= 1'b0;
    end else begin
      sync_1      <= data_i;
      data_s      <= sync_1;
      data_d      <= data_s;
      bit_valid_o <= 1'b0;
      minute_o    <= 1'b0;
      err_o       <= 1'b0;

      unique case (state)
        HUNT: begin
          if (rise) begin
            state <= PULSE;
            timer <= '0;
            cont  <= 1'b1;
          end
        end

        PULSE: begin
          if (timer != TIMER_MAX) timer <= timer + 8'd1;
          if (!data_s) cont <= 1'b0;
          if (timer == TA_8) a <= data_s;
          if (timer == TB_8) b <= data_s;
          // A marker is a carrier-off pulse lasting through the decision point.
          if (timer == TMARK_8) begin
            state <= GAP;
            if (cont && data_s) begin
              sec_o    <= '0;
              synced_o <= 1'b1;
              minute_o <= 1'b1;
            end else if (synced_o) begin
              if (sec_o < LAST_SEC) begin
                sec_o       <= sec_o + 6'd1;
                bit_valid_o <= 1'b1;
                bit_a_o     <= a;
                bit_b_o     <= b;
              end else begin
                err_o    <= 1'b1;
                synced_o <= 1'b0;
              end
            end
          end
        end

        GAP: begin
          if (timer == TTIME_8) begin
            err_o    <= 1'b1;
            synced_o <= 1'b0;
            state    <= HUNT;
            timer    <= '0;
          end else if (rise && timer >= TMIN_8) begin
            state <= PULSE;
            timer <= '0;
            cont  <= 1'b1;
          end else if (timer != TIMER_MAX) begin
            timer <= timer + 8'd1;
          end
        end

        default: state <= HUNT;
      endcase
    end
  end

endmodule

// File: tb/tb_msf_frame_sequencer.sv
// Bench for msf_frame_sequencer: a tick-history reference model checks every cycle,
// plus a table of seconds and hand-written sequences for the corner cases.
module tb_msf_frame_sequencer;

  localparam int T_A       = 15;
  localparam int T_B       = 25;
  localparam int T_MARK    = 45;
  localparam int T_MIN_SEC = 90;
  localparam int T_TIMEOUT = 150;

  localparam int K_NONE = 0;
  localparam int K_MIN  = 1;
  localparam int K_BIT  = 2;
  localparam int K_ERR  = 3;

  typedef struct {
    int off;
    int period;
    int kind;
    bit a;
    bit b;
    int sec;
    bit synced;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       data;
  logic       bit_valid;
  logic       bit_a;
  logic       bit_b;
  logic [5:0] sec;
  logic       minute;
  logic       synced;
  logic       err;

  int n_tests = 0;
  int n_fail  = 0;
  int tick    = 0;

  always #5 clk = ~clk;

  msf_frame_sequencer #(
    .T_A(T_A), .T_B(T_B), .T_MARK(T_MARK), .T_MIN_SEC(T_MIN_SEC), .T_TIMEOUT(T_TIMEOUT)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .data_i(data),
    .bit_valid_o(bit_valid),
    .bit_a_o(bit_a),
    .bit_b_o(bit_b),
    .sec_o(sec),
    .minute_o(minute),
    .synced_o(synced),
    .err_o(err)
  );

  // Reference model: remembers every synchronised sample by tick number and
  // decides each second from the absolute tick of its start.
  bit ds_hist [0:131071];
  bit m_s1, m_s, m_d;
  bit hunting;
  int start;
  bit check_en = 1'b0;
  bit e_valid, e_min, e_err, e_a, e_b, e_synced;
  int e_sec;

  always @(posedge clk) begin : model
    bit cur;
    bit rise;
    bit marker;
    int tm;
    tick++;
    if (rst) begin
      m_s1 = 0; m_s = 0; m_d = 0;
      hunting = 1; start = 0;
      e_valid = 0; e_min = 0; e_err = 0;
      e_a = 0; e_b = 0; e_sec = 0; e_synced = 0;
      check_en = 1;
    end else begin
      cur  = m_s;
      rise = cur && !m_d;
      m_d  = m_s;
      m_s  = m_s1;
      m_s1 = data;
      ds_hist[tick] = cur;
      e_valid = 0; e_min = 0; e_err = 0;
      if (hunting) begin
        if (rise) begin
          hunting = 0;
          start   = tick + 1;
        end
      end else begin
        tm = tick - start;
        if (tm == T_MARK) begin
          marker = 1;
          for (int k = start; k <= tick; k++) if (!ds_hist[k]) marker = 0;
          if (marker) begin
            e_sec = 0; e_synced = 1; e_min = 1;
          end else if (e_synced) begin
            if (e_sec < 59) begin
              e_sec++;
              e_valid = 1;
              e_a = ds_hist[start + T_A];
              e_b = ds_hist[start + T_B];
            end else begin
              e_err = 1; e_synced = 0;
            end
          end
        end else if (tm > T_MARK) begin
          if (tm == T_TIMEOUT) begin
            e_err = 1; e_synced = 0; hunting = 1;
          end else if (rise && tm >= T_MIN_SEC) begin
            start = tick + 1;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (check_en) begin
      n_tests++;
      if ({bit_valid, minute, err, synced, bit_a, bit_b, sec} !==
          {e_valid, e_min, e_err, e_synced, e_a, e_b, 6'(e_sec)}) begin
        n_fail++;
        $display("[TB] FAIL model tick %0d: got v%b m%b e%b s%b a%b b%b sec%0d expected v%b m%b e%b s%b a%b b%b sec%0d",
                 tick, bit_valid, minute, err, synced, bit_a, bit_b, sec,
                 e_valid, e_min, e_err, e_synced, e_a, e_b, e_sec);
      end
    end
  end

  // Strobe recorder used by the per-second checks.
  int n_valid, n_min, n_err;
  int cap_a, cap_b, cap_sec;

  always @(negedge clk) begin
    if (bit_valid === 1'b1) begin
      n_valid++;
      cap_a   = int'(bit_a);
      cap_b   = int'(bit_b);
      cap_sec = int'(sec);
    end
    if (minute === 1'b1) n_min++;
    if (err === 1'b1) n_err++;
  end

  task automatic clear_seen();
    n_valid = 0; n_min = 0; n_err = 0;
    cap_a = -1; cap_b = -1; cap_sec = -1;
  endtask

  task automatic check_output(input string name, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // One second: carrier off for 'off' ticks, optional 1-tick glitch at 'glitch_at'.
  task automatic apply_stimulus(input int off, input int period, input int glitch_at);
    clear_seen();
    for (int i = 0; i < period; i++) begin
      data = (i < off) || (glitch_at != 0 && i == glitch_at);
      @(negedge clk);
    end
  endtask

  task automatic idle(input int n);
    data = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic check_second(input string name, input vec_t v);
    check_output({name, " minute"}, n_min, (v.kind == K_MIN) ? 1 : 0);
    check_output({name, " valid"},  n_valid, (v.kind == K_BIT) ? 1 : 0);
    check_output({name, " err"},    n_err, (v.kind == K_ERR) ? 1 : 0);
    if (v.kind == K_BIT) begin
      check_output({name, " a"},   cap_a, int'(v.a));
      check_output({name, " b"},   cap_b, int'(v.b));
      check_output({name, " sec"}, cap_sec, v.sec);
    end
    check_output({name, " sec_hold"}, int'(sec), v.sec);
    check_output({name, " synced"},   int'(synced), int'(v.synced));
  endtask

  vec_t vecs [9];

  initial begin
    int cur_sec;
    vec_t v;
    vecs[0] = '{50, 100, K_MIN, 1'b0, 1'b0, 0, 1'b1};
    vecs[1] = '{20, 100, K_BIT, 1'b1, 1'b0, 1, 1'b1};
    vecs[2] = '{30, 100, K_BIT, 1'b1, 1'b1, 2, 1'b1};
    vecs[3] = '{ 5, 100, K_BIT, 1'b0, 1'b0, 3, 1'b1};
    vecs[4] = '{46, 100, K_BIT, 1'b1, 1'b1, 4, 1'b1};
    vecs[5] = '{10,  91, K_BIT, 1'b0, 1'b0, 5, 1'b1};
    vecs[6] = '{27, 100, K_BIT, 1'b1, 1'b1, 6, 1'b1};
    vecs[7] = '{47, 100, K_MIN, 1'b0, 1'b0, 0, 1'b1};
    vecs[8] = '{ 1, 100, K_BIT, 1'b0, 1'b0, 1, 1'b1};

    rst  = 1'b1;
    data = 1'b0;
    repeat (3) @(negedge clk);
    check_output("reset synced", int'(synced), 0);
    check_output("reset sec", int'(sec), 0);
    check_output("reset strobes", int'({bit_valid, minute, err, bit_a, bit_b}), 0);
    rst = 1'b0;
    idle(10);

    for (int i = 0; i < 9; i++) begin
      apply_stimulus(vecs[i].off, vecs[i].period, 0);
      check_second($sformatf("vec%0d", i), vecs[i]);
    end

    // Short glitch 40 ticks into the gap must not start a second.
    apply_stimulus(20, 100, T_MARK + 3 + 40);
    check_second("glitch sec", '{20, 100, K_BIT, 1'b1, 1'b0, 2, 1'b1});
    apply_stimulus(30, 100, 0);
    check_second("after glitch", '{30, 100, K_BIT, 1'b1, 1'b1, 3, 1'b1});

    // Second-count overflow after 60 non-marker seconds.
    apply_stimulus(50, 100, 0);
    check_second("ovf marker", '{50, 100, K_MIN, 1'b0, 1'b0, 0, 1'b1});
    for (cur_sec = 1; cur_sec <= 59; cur_sec++) begin
      apply_stimulus(20, 100, 0);
      check_output("ovf valid", n_valid, 1);
      check_output("ovf sec", cap_sec, cur_sec);
    end
    apply_stimulus(20, 100, 0);
    check_second("ovf 60th", '{20, 100, K_ERR, 1'b0, 1'b0, 59, 1'b0});

    // Loss of sync after a long silence.
    apply_stimulus(50, 100, 0);
    check_second("to marker", '{50, 100, K_MIN, 1'b0, 1'b0, 0, 1'b1});
    apply_stimulus(20, 100, 0);
    check_second("to bit", '{20, 100, K_BIT, 1'b1, 1'b0, 1, 1'b1});
    clear_seen();
    idle(200);
    check_output("timeout err", n_err, 1);
    check_output("timeout synced", int'(synced), 0);
    for (int i = 0; i < 2; i++) begin
      apply_stimulus(20, 100, 0);
      check_second("unsynced", '{20, 100, K_NONE, 1'b0, 1'b0, 1, 1'b0});
    end

    // Reset in the middle of a carrier-off pulse, data held high through it.
    apply_stimulus(50, 100, 0);
    data = 1'b1;
    repeat (20) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_output("midrst outputs",
                 int'({bit_valid, minute, err, synced, bit_a, bit_b, sec}), 0);
    rst = 1'b0;
    clear_seen();
    repeat (50) @(negedge clk);
    idle(60);
    check_output("midrst minute", n_min, 1);
    check_output("midrst valid", n_valid, 0);
    check_output("midrst err", n_err, 0);
    check_output("midrst synced", int'(synced), 1);

    // Random seconds, glitches and occasional resets against the model.
    for (int i = 0; i < 150; i++) begin
      int off, period, glitch;
      off    = $urandom_range(1, 60);
      period = $urandom_range(60, 170);
      glitch = 0;
      if ($urandom_range(0, 3) == 0 && off + 2 < period - 2)
        glitch = $urandom_range(off + 2, period - 2);
      apply_stimulus(off, period, glitch);
      if ($urandom_range(0, 39) == 0) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
      end
    end
    idle(200);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
